// File: rtl/uart_axil_driver_if.sv
// AXI4-lite bus bundle between uart_axil_driver (master) and the UART IP (slave).
interface uart_axil_driver_if #(
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/uart_axil_driver.sv
// uart_axil_driver: AXI4-lite initiator that configures the UART IP after reset,
// then polls its status register and moves bytes between the IP FIFOs and a
// local valid/ready byte stream pair.
// Optional macro UART_DRV_IRQ_EN: the idle gap becomes a wait on irq (or a
// pending tx byte) instead of a fixed POLL_GAP cycle count.
module uart_axil_driver #(
  parameter int          ADDR_WIDTH     = 5,
  parameter int          BASE_ADDR      = 0,
  parameter int          OFFSET_RX_BUFF = 0,
  parameter int          OFFSET_TX_BUFF = 4,
  parameter int          OFFSET_CONFIG  = 8,
  parameter int          OFFSET_STATUS  = 12,
  parameter logic [31:0] INIT_CONFIG    = 32'h0000_E204,
  parameter int          POLL_GAP       = 16
) (
  input  logic                      m_axi_aclk,
  input  logic                      m_axi_aresetn,
  uart_axil_driver_if.master        m_axi,
  input  logic [7:0]                tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [7:0]                rx_data,
  output logic [1:0]                rx_err,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  input  logic                      irq,
  output logic                      ready,
  output logic                      err_overrun,
  output logic                      err_parity,
  output logic                      err_frame,
  output logic                      bus_err
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_RX  = ADDR_WIDTH'(BASE_ADDR + OFFSET_RX_BUFF);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TX  = ADDR_WIDTH'(BASE_ADDR + OFFSET_TX_BUFF);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CFG = ADDR_WIDTH'(BASE_ADDR + OFFSET_CONFIG);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ST  = ADDR_WIDTH'(BASE_ADDR + OFFSET_STATUS);

  typedef enum logic [2:0] {
    INIT_WR, INIT_B, GAP, STAT_RD, DECIDE, RX_RD, TX_WR, TX_B
  } state_t;

  state_t                state_q;
  logic                  issued_q;
  logic                  awvalid_q, wvalid_q, bready_q;
  logic                  arvalid_q, rready_q;
  logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [31:0]           wdata_q;
  logic                  tx_ready_q, rx_valid_q, ready_q;
  logic [7:0]            rx_data_q;
  logic [1:0]            rx_err_q;
  logic                  err_ov_q, err_par_q, err_fr_q, bus_err_q;
  logic                  rx_empty_q, tx_full_q, last_rx_q;
`ifndef UART_DRV_IRQ_EN
  localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP - 1);
  logic [15:0]           gap_q;
  logic                  unused_irq;
  assign unused_irq = irq;
`endif

  // Handshake and arbitration terms derived from the registered state.
  logic aw_fire, w_fire, aw_clear, w_clear, r_fire, b_fire, b_err, r_err;
  logic rx_ok, tx_ok;
  logic unused_rdata;
  assign aw_fire  = awvalid_q & m_axi.awready;
  assign w_fire   = wvalid_q & m_axi.wready;
  assign aw_clear = ~awvalid_q | aw_fire;
  assign w_clear  = ~wvalid_q | w_fire;
  assign r_fire   = rready_q & m_axi.rvalid;
  assign b_fire   = bready_q & m_axi.bvalid;
  assign b_err    = (m_axi.bresp != 2'b00);
  assign r_err    = (m_axi.rresp != 2'b00);
  assign rx_ok    = ~rx_empty_q & ~rx_valid_q;
  assign tx_ok    = tx_valid & ~tx_full_q;
  assign unused_rdata = ^m_axi.rdata[31:10];

  // Controller FSM: owns every bus and stream register so all outputs are registered.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q    <= INIT_WR;
      issued_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_err_q   <= '0;
      ready_q    <= 1'b0;
      err_ov_q   <= 1'b0;
      err_par_q  <= 1'b0;
      err_fr_q   <= 1'b0;
      bus_err_q  <= 1'b0;
      rx_empty_q <= 1'b1;
      tx_full_q  <= 1'b0;
      last_rx_q  <= 1'b0;
`ifndef UART_DRV_IRQ_EN
      gap_q      <= '0;
`endif
    end else begin
      tx_ready_q <= 1'b0;
      err_ov_q   <= 1'b0;
      err_par_q  <= 1'b0;
      err_fr_q   <= 1'b0;
      bus_err_q  <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      case (state_q)
        INIT_WR, TX_WR: begin
          if (!issued_q) begin
            issued_q  <= 1'b1;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= (state_q == INIT_WR) ? ADDR_CFG : ADDR_TX;
            wdata_q   <= (state_q == INIT_WR) ? INIT_CONFIG : {24'h0, tx_data};
          end else begin
            if (aw_fire) awvalid_q <= 1'b0;
            if (w_fire)  wvalid_q  <= 1'b0;
            if (aw_clear && w_clear) begin
              issued_q <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= (state_q == INIT_WR) ? INIT_B : TX_B;
            end
          end
        end

        INIT_B, TX_B: begin
          if (b_fire) begin
            bready_q <= 1'b0;
            if (b_err) begin
              bus_err_q <= 1'b1;
              state_q   <= (state_q == INIT_B) ? INIT_WR : STAT_RD;
            end else begin
              if (state_q == INIT_B) ready_q    <= 1'b1;
              else                   tx_ready_q <= 1'b1;
              state_q <= STAT_RD;
            end
          end
        end

        STAT_RD, RX_RD: begin
          if (!issued_q) begin
            issued_q  <= 1'b1;
            arvalid_q <= 1'b1;
            rready_q  <= 1'b1;
            araddr_q  <= (state_q == STAT_RD) ? ADDR_ST : ADDR_RX;
          end else begin
            if (arvalid_q && m_axi.arready) arvalid_q <= 1'b0;
            if (r_fire) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b0;
              issued_q  <= 1'b0;
              if (r_err) bus_err_q <= 1'b1;
              if (state_q == STAT_RD) begin
                if (r_err) begin
                  state_q <= GAP;
`ifndef UART_DRV_IRQ_EN
                  gap_q   <= GAP_LOAD;
`endif
                end else begin
                  rx_empty_q <= m_axi.rdata[0];
                  tx_full_q  <= m_axi.rdata[3];
                  err_ov_q   <= m_axi.rdata[6];
                  err_par_q  <= m_axi.rdata[5];
                  err_fr_q   <= m_axi.rdata[4];
                  state_q    <= DECIDE;
                end
              end else begin
                if (!r_err) begin
                  rx_data_q  <= m_axi.rdata[7:0];
                  rx_err_q   <= m_axi.rdata[9:8];
                  rx_valid_q <= 1'b1;
                end
                state_q <= STAT_RD;
              end
            end
          end
        end

        DECIDE: begin
          if (rx_ok && (!tx_ok || !last_rx_q)) begin
            state_q   <= RX_RD;
            last_rx_q <= 1'b1;
          end else if (tx_ok) begin
            state_q   <= TX_WR;
            last_rx_q <= 1'b0;
          end else begin
            state_q <= GAP;
`ifndef UART_DRV_IRQ_EN
            gap_q   <= GAP_LOAD;
`endif
          end
        end

        GAP: begin
`ifdef UART_DRV_IRQ_EN
          if (irq || (tx_valid && !tx_full_q)) state_q <= STAT_RD;
`else
          if (gap_q == '0) state_q <= STAT_RD;
          else             gap_q   <= gap_q - 16'd1;
`endif
        end

        default: state_q <= INIT_WR;
      endcase
    end
  end

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_err      = rx_err_q;
  assign rx_valid    = rx_valid_q;
  assign ready       = ready_q;
  assign err_overrun = err_ov_q;
  assign err_parity  = err_par_q;
  assign err_frame   = err_fr_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_uart_axil_driver.sv
// Testbench for uart_axil_driver: a UART IP register model answers the AXI-lite
// bus, stimulus pushes expected bus writes and rx bytes into queues, and a
// monitor pops and compares them as the DUT presents them.
module tb_uart_axil_driver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_axil_driver_if #(.ADDR_WIDTH(5)) axi ();

  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic       irq      = 1'b0;
  logic       tx_ready, rx_valid, ready;
  logic [7:0] rx_data;
  logic [1:0] rx_err;
  logic       err_overrun, err_parity, err_frame, bus_err;

  uart_axil_driver #(.ADDR_WIDTH(5), .BASE_ADDR(0), .POLL_GAP(16)) dut (
    .m_axi_aclk   (clk),
    .m_axi_aresetn(rst_n),
    .m_axi        (axi),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_err       (rx_err),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .irq          (irq),
    .ready        (ready),
    .err_overrun  (err_overrun),
    .err_parity   (err_parity),
    .err_frame    (err_frame),
    .bus_err      (bus_err)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [9:0] exp_rx[$];
  bit         oplog[$];   // 1 = RX_BUFF read, 0 = TX_BUFF write

  int n_checks = 0, n_errors = 0;
  int n_txready = 0, n_buserr = 0, n_par = 0, n_fr = 0, n_ov = 0, rx_reads = 0;

  // UART IP model state
  logic [9:0] rxq[$];
  logic       tx_full_flag = 1'b0;
  logic [2:0] stat_err     = 3'b000;
  int         init_slverr_n = 0;
  int         tx_slverr_n   = 0;
  bit         b_hold        = 1'b0;
  bit         b_pending     = 1'b0;
  logic [1:0] b_resp_pend   = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // IP model: answers on the falling edge so the handshake lands on the next rising edge.
  always @(negedge clk) begin
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = 32'h0;
    axi.rresp   = 2'b00;
    if (!rst_n) begin
      b_pending   = 1'b0;
      axi.bresp   = 2'b00;
    end else begin
      if (axi.awvalid && axi.wvalid && !b_pending) begin
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        b_pending   = 1'b1;
        b_resp_pend = 2'b00;
        if (axi.awaddr == 5'd8 && init_slverr_n > 0) begin
          b_resp_pend = 2'b10;
          init_slverr_n--;
        end else if (axi.awaddr == 5'd4 && tx_slverr_n > 0) begin
          b_resp_pend = 2'b10;
          tx_slverr_n--;
        end
      end
      if (b_pending && axi.bready && !b_hold) begin
        axi.bvalid = 1'b1;
        axi.bresp  = b_resp_pend;
        b_pending  = 1'b0;
      end
      if (axi.arvalid && axi.rready) begin
        axi.arready = 1'b1;
        axi.rvalid  = 1'b1;
        if (axi.araddr == 5'd12) begin
          axi.rdata = {25'b0, stat_err, tx_full_flag, 2'b00, (rxq.size() == 0)};
          stat_err  = 3'b000;
        end else if (axi.araddr == 5'd0) begin
          if (rxq.size() == 0) axi.rresp = 2'b10;
          else                 axi.rdata = {22'b0, rxq.pop_front()};
        end else begin
          axi.rresp = 2'b10;
        end
      end
    end
  end

  // Monitor: compares each presented transfer against the scoreboard queues.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (axi.awvalid || axi.wvalid) check("aw_w_together", axi.awvalid, axi.wvalid);
      if (axi.awvalid && axi.awready && axi.wvalid && axi.wready) begin
        check("wr_expected", exp_wr.size() != 0, 1);
        check("wr_strb_prot", {axi.wstrb, axi.awprot}, {4'hF, 3'b000});
        if (exp_wr.size() != 0) begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr", axi.awaddr, e.addr);
          check("wr_data", axi.wdata, e.data);
        end
        if (axi.awaddr == 5'd4) oplog.push_back(1'b0);
      end
      if (axi.arvalid && axi.arready) begin
        check("ar_prot", axi.arprot, 3'b000);
        if (axi.araddr == 5'd0) begin
          rx_reads++;
          oplog.push_back(1'b1);
        end
      end
      if (rx_valid && rx_ready) begin
        check("rx_expected", exp_rx.size() != 0, 1);
        if (exp_rx.size() != 0) check("rx_byte", {rx_err, rx_data}, exp_rx.pop_front());
      end
      if (tx_ready)    n_txready++;
      if (bus_err)     n_buserr++;
      if (err_parity)  n_par++;
      if (err_frame)   n_fr++;
      if (err_overrun) n_ov++;
    end
  end

  logic [7:0] txb [4];
  logic [7:0] rxb [4];

  initial begin
    int k, base_rd, base_tx, base_be, base_p, base_f, base_o, same;
    txb = '{8'h81, 8'h82, 8'h83, 8'h84};
    rxb = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awvalid", axi.awvalid, 0);
    check("rst_wvalid", axi.wvalid, 0);
    check("rst_arvalid", axi.arvalid, 0);
    check("rst_bready_rready", {axi.bready, axi.rready}, 0);
    check("rst_stream", {tx_ready, rx_valid, ready, bus_err}, 0);
    check("rst_addr_data", {axi.awaddr, axi.araddr, axi.wdata}, 0);

    // Init write, first response SLVERR then retried
    init_slverr_n = 1;
    exp_wr.push_back('{addr: 5'd8, data: 32'h0000_E204});
    exp_wr.push_back('{addr: 5'd8, data: 32'h0000_E204});
    rst_n = 1'b1;
    k = 0;
    while (!ready && k < 200) begin @(posedge clk); #1; k++; end
    check("init_ready", ready, 1);
    check("init_bus_err_cnt", n_buserr, 1);

    // Rx path with held rx_valid
    base_rd = rx_reads;
    rxq.push_back({2'b00, 8'h5A});
    exp_rx.push_back({2'b00, 8'h5A});
    k = 0;
    while (!rx_valid && k < 200) begin @(posedge clk); #1; k++; end
    check("rx_valid_seen", rx_valid, 1);
    rxq.push_back({2'b00, 8'h6B});
    exp_rx.push_back({2'b00, 8'h6B});
    repeat (10) @(posedge clk);
    #1;
    check("rx_hold_valid", rx_valid, 1);
    check("rx_hold_data", {rx_err, rx_data}, {2'b00, 8'h5A});
    check("rx_no_second_read", rx_reads - base_rd, 1);
    rx_ready = 1'b1;
    k = 0;
    while (exp_rx.size() != 0 && k < 300) begin @(posedge clk); #1; k++; end
    rx_ready = 1'b0;
    check("rx_drained", exp_rx.size(), 0);
    check("rx_read_cnt", rx_reads - base_rd, 2);

    // Tx path
    base_tx = n_txready;
    exp_wr.push_back('{addr: 5'd4, data: 32'h0000_00A5});
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    k = 0;
    while (!tx_ready && k < 300) begin @(posedge clk); #1; k++; end
    check("tx_ready_seen", tx_ready, 1);
    tx_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("tx_single_pulse", n_txready - base_tx, 1);

    // Tx full: nothing written while status says full, then SLVERR and retry
    tx_full_flag = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    base_tx = n_txready;
    base_be = n_buserr;
    tx_data  = 8'h33;
    tx_valid = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("tx_full_no_ready", n_txready - base_tx, 0);
    tx_slverr_n = 1;
    exp_wr.push_back('{addr: 5'd4, data: 32'h0000_0033});
    exp_wr.push_back('{addr: 5'd4, data: 32'h0000_0033});
    tx_full_flag = 1'b0;
    k = 0;
    while (!tx_ready && k < 300) begin @(posedge clk); #1; k++; end
    check("tx_retry_ready", tx_ready, 1);
    tx_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("tx_retry_bus_err", n_buserr - base_be, 1);
    check("tx_retry_pulses", n_txready - base_tx, 1);

    // Fairness: both directions pending continuously
    oplog.delete();
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rxq.push_back({2'b00, rxb[i]});
      exp_rx.push_back({2'b00, rxb[i]});
      exp_wr.push_back('{addr: 5'd4, data: {24'h0, txb[i]}});
    end
    tx_data  = txb[0];
    tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (!tx_ready && k < 300) begin @(posedge clk); #1; k++; end
      check("fair_tx_ready", tx_ready, 1);
      if (i < 3) tx_data = txb[i+1];
      else       tx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    k = 0;
    while (exp_rx.size() != 0 && k < 300) begin @(posedge clk); #1; k++; end
    check("fair_rx_drained", exp_rx.size(), 0);
    check("fair_op_count", oplog.size(), 8);
    same = 0;
    for (int i = 1; i < oplog.size(); i++) if (oplog[i] == oplog[i-1]) same++;
    check("fair_alternate", same, 0);

    // Parity error frame
    base_p = n_par; base_f = n_fr; base_o = n_ov;
    stat_err = 3'b010;
    rxq.push_back({2'b10, 8'hC3});
    exp_rx.push_back({2'b10, 8'hC3});
    k = 0;
    while (exp_rx.size() != 0 && k < 300) begin @(posedge clk); #1; k++; end
    repeat (30) @(posedge clk);
    #1;
    check("par_rx_done", exp_rx.size(), 0);
    check("par_pulse_once", n_par - base_p, 1);
    check("par_no_frame_ov", (n_fr - base_f) + (n_ov - base_o), 0);
    rx_ready = 1'b0;

    // Reset during the TX_B wait
    b_hold = 1'b1;
    exp_wr.push_back('{addr: 5'd4, data: 32'h0000_0077});
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    k = 0;
    while (!axi.bready && k < 300) begin @(posedge clk); #1; k++; end
    check("mid_bready_seen", axi.bready, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 0);
    check("mid_rst_readys", {axi.bready, axi.rready}, 0);
    check("mid_rst_ready", ready, 0);
    tx_valid = 1'b0;
    b_hold   = 1'b0;
    exp_wr.push_back('{addr: 5'd8, data: 32'h0000_E204});
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    while (!ready && k < 200) begin @(posedge clk); #1; k++; end
    check("reinit_ready", ready, 1);

    repeat (20) @(posedge clk);
    #1;
    check("final_wr_queue", exp_wr.size(), 0);
    check("final_rx_queue", exp_rx.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
